// File: rtl/seq_bit_serializer_pkg.sv
// Shared definitions for the bit serializer and the downstream detector bench.
package seq_bit_serializer_pkg;

    // Serializer FSM states; encodings are shared with the detector bench.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    // Default level driven on x while no word is being shifted.
    localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage : seq_bit_serializer_pkg

// File: rtl/seq_hold_reg.sv
// One-entry holding buffer; a read and a write on the same edge leave it full
// with the newly written word.
module seq_hold_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             full_nxt_c
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    // Next occupancy and contents; clear wins over everything.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (clr) begin
            data_d = '0;
            full_d = 1'b0;
        end else begin
            if (wr) begin
                data_d = wdata;
            end
            full_d = wr | (full_q & ~rd);
        end
    end

    // Buffer storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign rdata      = data_q;
    assign full       = full_q;
    assign full_nxt_c = full_d;

endmodule : seq_hold_reg

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: valid/ready word input,
// one registered bit per clock on x, with a hold buffer for gapless streaming.
module seq_bit_serializer
    import seq_bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             last_bit_q, last_bit_d;
    logic             busy_q, busy_d;

    logic             hold_wr, hold_rd;
    logic             hold_full, hold_full_nxt_c;
    logic [WIDTH-1:0] hold_data;
    logic             at_last_c;
    logic             drain_c;
    logic             accept_c;

    seq_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (abort),
        .wr         (hold_wr),
        .rd         (hold_rd),
        .wdata      (din),
        .rdata      (hold_data),
        .full       (hold_full),
        .full_nxt_c (hold_full_nxt_c)
    );

    // Hold frees on the final-bit edge, so a new word may land there too.
    assign at_last_c = (state_q == S_SHIFT) && (bit_cnt_q == LAST_CNT);
    assign drain_c   = at_last_c & hold_full;
    assign din_ready = reset_n & ~abort & (~hold_full | drain_c);
    assign accept_c  = din_valid & din_ready;

    // Next-state, shifter, counter and hold control.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        hold_wr   = 1'b0;
        hold_rd   = 1'b0;
        if (abort) begin
            state_d   = S_IDLE;
            shift_d   = '0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        state_d   = S_SHIFT;
                        shift_d   = din;
                        bit_cnt_d = '0;
                    end
                end
                S_SHIFT: begin
                    if (at_last_c) begin
                        bit_cnt_d = '0;
                        if (hold_full) begin
                            shift_d = hold_data;
                            hold_rd = 1'b1;
                            hold_wr = accept_c;
                        end else if (accept_c) begin
                            // Hold empty: the new word goes straight to the shifter.
                            shift_d = din;
                        end else begin
                            state_d = S_IDLE;
                            shift_d = '0;
                        end
                    end else begin
                        shift_d   = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                              : {1'b0, shift_q[WIDTH-1:1]};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        hold_wr   = accept_c;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Registered outputs derived from the next shifter state.
    always_comb begin
        x_d        = IDLE_BIT;
        x_valid_d  = 1'b0;
        last_bit_d = 1'b0;
        busy_d     = hold_full_nxt_c;
        if (state_d == S_SHIFT) begin
            x_d        = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
            x_valid_d  = 1'b1;
            last_bit_d = (bit_cnt_d == LAST_CNT);
            busy_d     = 1'b1;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            x_q        <= IDLE_BIT;
            x_valid_q  <= 1'b0;
            last_bit_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            x_q        <= x_d;
            x_valid_q  <= x_valid_d;
            last_bit_q <= last_bit_d;
            busy_q     <= busy_d;
        end
    end

    assign x        = x_q;
    assign x_valid  = x_valid_q;
    assign last_bit = last_bit_q;
    assign busy     = busy_q;

endmodule : seq_bit_serializer
